// File: rtl/hilo_pkg.sv
// Purpose: shared types and encodings for the HI/LO multiply unit and the decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum for hilo_unit and the regsel read-select encoding
// used by both the decoder and the HI/LO read mux.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } hilo_state_t;

    localparam logic [1:0] REGSEL_NONE = 2'd0;
    localparam logic [1:0] REGSEL_HI   = 2'd1;
    localparam logic [1:0] REGSEL_LO   = 2'd2;

endpackage

// File: rtl/hilo_shift_add.sv
// Purpose: radix-2 shift-add multiply datapath (unsigned magnitudes) with bit counter.
// Latency: load in one cycle, then one product bit per step; WIDTH steps total.
// Backpressure: none; advances only when the controlling FSM asserts step.
//
// Ports:
//   clk, rst            core clock, async active-high reset
//   load                capture operands, clear accumulator, counter = WIDTH
//   step                perform one add/shift iteration, counter - 1
//   mcand_in, mplier_in unsigned operands captured on load
//   acc                 2*WIDTH accumulator (full product after WIDTH steps)
//   last_step           the current step is the final one (counter == 1)
module hilo_shift_add
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last_step
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [WIDTH:0]     sum;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        // Upper half plus (optionally) the multiplicand; the extra bit keeps
        // the carry, which becomes the new MSB after the right shift.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

        if (load) begin
            acc_d    = '0;
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            cnt_d    = CW'(WIDTH);
        end else if (step) begin
            acc_d    = {sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc       = acc_q;
    assign last_step = (cnt_q == CW'(1));

endmodule

// File: rtl/hilo_unit.sv
// Purpose: multi-cycle mult/multu unit with HI/LO registers and mfhi/mflo read port.
// Latency: start at edge 0, RUN cycles 1..WIDTH, commit (done) in cycle WIDTH+1.
// Backpressure: stall_hilo holds dependent EX instructions while a product is pending.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   enhilo_EX, signed_EX  start a multiply; signed_EX selects mult vs multu
//   a_EX, b_EX            rs / rt operands, sampled on an accepted start
//   regsel_EX             read select (none / HI / LO)
//   hilo_data_EX          committed HI or LO, 0 when no read is selected
//   stall_hilo            hold request for dependent instructions
//   busy, done            multiply in flight / HI,LO written this cycle
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enhilo_EX,
    input  logic             signed_EX,
    input  logic [WIDTH-1:0] a_EX,
    input  logic [WIDTH-1:0] b_EX,
    input  logic [1:0]       regsel_EX,
    output logic [WIDTH-1:0] hilo_data_EX,
    output logic             stall_hilo,
    output logic             busy,
    output logic             done
);

    hilo_state_t        state_q, state_d;
    logic               neg_q,   neg_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;

    logic               load;
    logic               step;
    logic               last_step;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitudes for signed operands. The most negative value maps to
    // 2^(WIDTH-1) read as unsigned, so no overflow case exists.
    assign a_mag = (signed_EX & a_EX[WIDTH-1]) ? (WIDTH'(0) - a_EX) : a_EX;
    assign b_mag = (signed_EX & b_EX[WIDTH-1]) ? (WIDTH'(0) - b_EX) : b_EX;

    assign product = neg_q ? ((2*WIDTH)'(0) - acc) : acc;

    assign load = (state_q == IDLE) & enhilo_EX;
    assign step = (state_q == RUN);

    hilo_shift_add #(
        .WIDTH     (WIDTH)
    ) u_shift_add (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .acc       (acc),
        .last_step (last_step)
    );

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (enhilo_EX) begin
                    neg_d   = signed_EX & (a_EX[WIDTH-1] ^ b_EX[WIDTH-1]);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // HI and LO are written in the same edge so a reader never
                // sees half of a product.
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIX);

    // Only instructions that touch HI/LO wait on the multiply.
    assign stall_hilo = busy & (enhilo_EX | (regsel_EX == REGSEL_HI) |
                                (regsel_EX == REGSEL_LO));

    always_comb begin
        case (regsel_EX)
            REGSEL_HI: hilo_data_EX = hi_q;
            REGSEL_LO: hilo_data_EX = lo_q;
            default:   hilo_data_EX = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enhilo_EX;
    logic          signed_EX;
    logic [W-1:0]  a_EX;
    logic [W-1:0]  b_EX;
    logic [1:0]    regsel_EX;
    logic [W-1:0]  hilo_data_EX;
    logic          stall_hilo;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    hilo_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enhilo_EX    (enhilo_EX),
        .signed_EX    (signed_EX),
        .a_EX         (a_EX),
        .b_EX         (b_EX),
        .regsel_EX    (regsel_EX),
        .hilo_data_EX (hilo_data_EX),
        .stall_hilo   (stall_hilo),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product: sign- or zero-extend to 64 bits, multiply modulo 2^64.
    function automatic logic [63:0] mul_model(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[W-1]}}, a} : {32'b0, a};
        eb = s ? {{32{b[W-1]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Behavioural model: a pending product ages one cycle per edge and is
    // committed at the end of cycle W+1 after its start.
    logic         m_pend;
    int           m_age;
    logic [63:0]  m_prod;
    logic [W-1:0] m_hi, m_lo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_age  <= 0;
            m_prod <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_pend) begin
            if (m_age == W + 1) begin
                m_hi   <= m_prod[63:32];
                m_lo   <= m_prod[31:0];
                m_pend <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (enhilo_EX) begin
            m_pend <= 1'b1;
            m_age  <= 1;
            m_prod <= mul_model(signed_EX, a_EX, b_EX);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, m_pend);
            chk("done", done, m_pend && (m_age == W + 1));
            chk("stall", stall_hilo, m_pend && (enhilo_EX || regsel_EX == 2'd1 || regsel_EX == 2'd2));
            chk("data", hilo_data_EX, (regsel_EX == 2'd1) ? m_hi :
                                      (regsel_EX == 2'd2) ? m_lo : '0);
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a start in the current cycle (cycle 0); returns in cycle 1.
    task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        enhilo_EX = 1'b1;
        signed_EX = s;
        a_EX      = a;
        b_EX      = b;
        next_cyc();
        enhilo_EX = 1'b0;
    endtask

    // Called in cycle 'first'; returns at the negedge of the cycle showing done.
    task automatic wait_done(input int first, output int n);
        n = first;
        while (n < 300) begin
            @(negedge clk);
            if (done) return;
            next_cyc();
            n++;
        end
        n = -1;
    endtask

    task automatic read_check(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        regsel_EX = 2'd1;
        #1 chk({tag, "_mfhi"}, hilo_data_EX, ehi);
        regsel_EX = 2'd2;
        #1 chk({tag, "_mflo"}, hilo_data_EX, elo);
        regsel_EX = 2'd0;
    endtask

    logic         vs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] va [5] = '{32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] vb [5] = '{32'd5, 32'd3, 32'd3, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] vh [5] = '{32'h0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h40000000};
    logic [W-1:0] vl [5] = '{32'hF, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'h1, 32'h0};

    initial begin
        int n;
        int dc;
        rst       = 1'b1;
        enhilo_EX = 1'b0;
        signed_EX = 1'b0;
        a_EX      = '0;
        b_EX      = '0;
        regsel_EX = 2'd0;
        repeat (2) next_cyc();

        // Reset state, with a start request and a read present.
        enhilo_EX = 1'b1;
        regsel_EX = 2'd1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall_hilo, 1'b0);
        chk("rst_data", hilo_data_EX, 32'h0);
        enhilo_EX = 1'b0;
        regsel_EX = 2'd0;
        next_cyc();
        rst    = 1'b0;
        chk_on = 1'b1;
        next_cyc();

        // Directed product vectors.
        for (int i = 0; i < 5; i++) begin
            start(vs[i], va[i], vb[i]);
            wait_done(1, n);
            chk("done_cycle", n, 33);
            next_cyc();
            read_check("vec", vh[i], vl[i]);
            next_cyc();
        end

        // mflo issued in cycle 1: stalled through cycle 33, free at 34 with new LO.
        start(1'b0, 32'd7, 32'd9);
        regsel_EX = 2'd2;
        n  = 1;
        dc = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!stall_hilo) break;
            dc++;
            next_cyc();
            n++;
        end
        chk("stall_release_cycle", n, 34);
        chk("stall_cycles", dc, 33);
        chk("stall_release_lo", hilo_data_EX, 32'd63);
        next_cyc();
        regsel_EX = 2'd0;
        next_cyc();

        // Second mult issued during RUN: accepted at 34, done at 67.
        start(1'b0, 32'd6, 32'd7);
        repeat (4) next_cyc();
        enhilo_EX = 1'b1;
        signed_EX = 1'b1;
        a_EX      = 32'hFFFFFFFD;
        b_EX      = 32'd4;
        n = 5;
        while (n < 200) begin
            @(negedge clk);
            if (!stall_hilo) break;
            next_cyc();
            n++;
        end
        chk("second_accept_cycle", n, 34);
        next_cyc();
        enhilo_EX = 1'b0;
        wait_done(n + 1, n);
        chk("second_done_cycle", n, 67);
        next_cyc();
        read_check("b2b", 32'hFFFFFFFF, 32'hFFFFFFF4);
        next_cyc();

        // Reset in the middle of RUN after HI/LO = 1/2.
        start(1'b0, 32'd2, 32'h80000001);
        wait_done(1, n);
        next_cyc();
        read_check("pre_rst", 32'h1, 32'h2);
        next_cyc();
        start(1'b0, 32'd5, 32'd5);
        repeat (9) next_cyc();
        regsel_EX = 2'd1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hi", hilo_data_EX, 32'h0);
        regsel_EX = 2'd2;
        #1 chk("midrst_lo", hilo_data_EX, 32'h0);
        regsel_EX = 2'd0;
        next_cyc();
        rst = 1'b0;
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("no_done_after_rst", dc, 0);
        next_cyc();
        read_check("post_rst", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle HI/LO multiply unit in the EX stage of the pipelined MIPS core. It responds to the decoder's `enhilo_EX` (mult/multu) and `regsel_EX` (mfhi/mflo) controls. It runs a radix-2 shift-add multiply, commits the 64-bit product to the HI/LO registers, and raises a stall request while a product is pending.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enhilo_EX`  in  1  start a multiply (mult or multu in EX).
- `signed_EX`  in  1  1 = mult (two's complement), 0 = multu; sampled with `enhilo_EX`.
- `a_EX`  in  WIDTH  rs operand; sampled at start.
- `b_EX`  in  WIDTH  rt operand; sampled at start.
- `regsel_EX`  in  2  read select: 0 = none, 1 = mfhi, 2 = mflo, 3 = none.
- `hilo_data_EX`  out  WIDTH  HI when `regsel_EX`=1, LO when 2, else 0. Combinational from the committed registers.
- `stall_hilo`  out  1  pipeline hold request.
- `busy`  out  1  a multiply is in flight (state is not IDLE).
- `done`  out  1  one-cycle pulse in the cycle HI/LO are written.

## Operation
- States are IDLE, RUN and FIX.
- **IDLE, start accepted** (`enhilo_EX`=1):
  - latch `|a|` and `|b|` when `signed_EX`=1, otherwise the raw operands.
  - latch `neg` = `signed_EX & (a[msb] ^ b[msb])`.
  - clear the 2·WIDTH accumulator, load counter = WIDTH, go to RUN.
- **RUN**, one cycle per bit:
  - if multiplier LSB = 1, add the multiplicand into the upper half of the accumulator (carry kept in a WIDTH+1 adder).
  - shift the accumulator and multiplier right by 1; decrement the counter.
  - go to FIX when the counter reaches 0.
- **FIX**: product = `neg` ? two's-complement negation of the accumulator : accumulator, over 2·WIDTH bits.
  - HI ← product[2W-1:W], LO ← product[W-1:0], written atomically.
  - `done`=1; go to IDLE.
- HI/LO keep their old values until FIX. A multiply never produces a partially updated HI/LO.
- `stall_hilo` = `busy & (enhilo_EX | regsel_EX==1 | regsel_EX==2)`.
  - A dependent instruction is held in EX until the product commits.
  - Unrelated instructions are not stalled.
- `enhilo_EX` while busy is ignored by the FSM (it is stalled). It is accepted in the first IDLE cycle after FIX.
- `enhilo_EX` and a read together in IDLE: the read returns the current (old) HI/LO and the multiply starts.
- Arithmetic is exact for all inputs. The magnitude of −2^(W−1) is 2^(W−1) unsigned, so no overflow case exists.

## Timing
- **Reset** (async, any state): state = IDLE, HI = LO = 0, accumulator/counter = 0. Outputs: `busy`=0, `done`=0, `stall_hilo`=0, `hilo_data_EX`=0.
- **Latency**: start at edge 0; RUN occupies cycles 1..WIDTH; FIX is cycle WIDTH+1, in which `done`=1. The new HI/LO are visible on `hilo_data_EX` from cycle WIDTH+2.
- With WIDTH=32, the earliest non-stalled mfhi after mult is 34 cycles after the start.
- `busy` is 1 from cycle 1 through cycle WIDTH+1 inclusive.
- **Back-to-back multiplies**: the second start is accepted in cycle WIDTH+2, so the minimum issue interval is WIDTH+2 cycles.
- **Reset asserted mid-RUN**: the product is discarded, and HI/LO are 0 (not the old values).

## Structure
- `hilo_pkg` holds:
  - the `hilo_state_t` enum (IDLE, RUN, FIX);
  - `REGSEL_NONE`=2'd0, `REGSEL_HI`=2'd1, `REGSEL_LO`=2'd2.
- The same package is imported by the decoder so both ends share the regsel encoding.
- One sub-module: `hilo_shift_add`, the accumulator/multiplier shift datapath with a counter, driven by load/step controls from the FSM.
- The top level holds the FSM, sign handling, HI/LO registers, read mux and stall logic.

## Test plan
- mult a=3, b=5 → `done` at cycle 33; then mfhi=0x00000000, mflo=0x0000000F.
- mult a=0xFFFFFFFE (−2), b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. mult 0x80000000×0x80000000 → HI=0x40000000, LO=0x00000000.
- mflo issued on the cycle after a start → `stall_hilo`=1 for cycles 1..33, 0 at cycle 34, with `hilo_data_EX` equal to the new LO.
- A second mult during RUN → stalled; accepted at cycle 34; its `done` at cycle 67.
- `rst` pulsed at RUN cycle 10 after HI/LO held 0x1/0x2 → immediately `busy`=0 and HI=LO=0; no `done` pulse follows.
